// File: rtl/chip_pkg.sv
// rtl/chip_pkg.sv - shared types and constants for the frame push block
//
// Purpose: FSM state encoding and the default frame length shared by the
// frame buffer top level and its bench.
// Ports: none (package).

package chip_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUF  = 3'd1,
    S_HDR  = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd7
  } state_t;

  localparam int LEN_CHIP = 4000;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO
//
// Purpose: holds captured samples until they are pushed to the UART.
// rd_data always shows the oldest word; rd_en pops it.
// Ports:
//   clk_sys, rst_n      clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data      push a word (ignored when full)
//   rd_en, rd_data      pop the head word (ignored when empty)
//   empty, full, count  occupancy status

module sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(2**AW));

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chip_frame_push.sv
// rtl/chip_frame_push.sv - frame buffer between sample datapath and UART
//
// Purpose: captures a configurable number of samples into a FIFO, then
// pushes them (optionally after a header word) to the UART one word per
// tx_vld/tx_done handshake. Continuous or armed single-shot capture.
// Ports:
//   clk_sys, rst_n              clock, asynchronous active-low reset
//   cfg_len, cfg_single, arm    frame length, capture mode, arm pulse
//   cfg_hdr_en, cfg_hdr         optional header word
//   d_data, d_vld, buf_rdy      sample input and acceptance
//   tx_data, tx_vld, tx_done    word output handshake to UART
//   busy, frame_done, drop_cnt  status

module chip_frame_push #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int LW = 20
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_single,
  input  logic          arm,
  input  logic          cfg_hdr_en,
  input  logic [DW-1:0] cfg_hdr,
  input  logic [DW-1:0] d_data,
  input  logic          d_vld,
  output logic          buf_rdy,
  output logic [DW-1:0] tx_data,
  output logic          tx_vld,
  input  logic          tx_done,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   drop_cnt
);

  import chip_pkg::*;

  localparam logic [LW-1:0] DEPTH_L = LW'(2**AW);

  state_t        state;
  logic          arm_q;
  logic          armed;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] len_q;
  logic [LW-1:0] wr_cnt;
  logic [LW-1:0] rd_cnt;
  logic [DW-1:0] hdr_q;
  logic          hdr_en_q;
  logic          pending;
  logic          accept;
  logic          last_wr;
  logic          bypass;
  logic          done_ok;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          fifo_unused;

  // Clamp the requested length into 1..depth so the FIFO can never overflow.
  always_comb begin
    len_eff = cfg_len;
    if (cfg_len > DEPTH_L) len_eff = DEPTH_L;
    if (cfg_len == '0)     len_eff = LW'(1);
  end

  // Continuous mode is permanently armed; single-shot needs a stored arm.
  assign armed   = ~cfg_single | arm_q;
  assign buf_rdy = ((state == S_IDLE) & armed) | (state == S_BUF);
  assign busy    = (state != S_IDLE);
  assign accept  = d_vld & buf_rdy;
  assign last_wr = (state == S_BUF) & accept & ((wr_cnt + LW'(1)) == len_q);
  assign done_ok = tx_done & pending & ((state == S_HDR) | (state == S_PUSH));

  // A one-sample frame without header goes straight to the UART register,
  // so the FIFO is not touched and the first word needs no read-through.
  assign bypass  = (state == S_IDLE) & (len_eff == LW'(1)) & ~cfg_hdr_en;
  assign fifo_wr = accept & ~bypass & ~fifo_full;

  always_comb begin
    fifo_rd = 1'b0;
    if (last_wr & ~hdr_en_q)                            fifo_rd = 1'b1;
    if ((state == S_HDR) & done_ok)                     fifo_rd = 1'b1;
    if ((state == S_PUSH) & done_ok & (rd_cnt != len_q)) fifo_rd = 1'b1;
  end

  assign fifo_unused = ^fifo_count;

  sync_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (d_data),
    .rd_en   (fifo_rd & ~fifo_empty),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Every issue loads tx_data and pulses tx_vld on the same edge, so the
  // word is visible one cycle after the event that triggered it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      arm_q      <= 1'b0;
      len_q      <= '0;
      hdr_q      <= '0;
      hdr_en_q   <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_vld     <= 1'b0;
      frame_done <= 1'b0;
      if (arm) arm_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            len_q    <= len_eff;
            hdr_q    <= cfg_hdr;
            hdr_en_q <= cfg_hdr_en;
            wr_cnt   <= LW'(1);
            rd_cnt   <= '0;
            // Frame start consumes the arm, including one arriving this cycle.
            if (cfg_single) arm_q <= 1'b0;
            if (len_eff == LW'(1)) begin
              tx_vld  <= 1'b1;
              pending <= 1'b1;
              if (cfg_hdr_en) begin
                state   <= S_HDR;
                tx_data <= cfg_hdr;
              end else begin
                state   <= S_PUSH;
                tx_data <= d_data;
                rd_cnt  <= LW'(1);
              end
            end else begin
              state <= S_BUF;
            end
          end
        end
        S_BUF: begin
          if (accept) wr_cnt <= wr_cnt + LW'(1);
          if (last_wr) begin
            tx_vld  <= 1'b1;
            pending <= 1'b1;
            if (hdr_en_q) begin
              state   <= S_HDR;
              tx_data <= hdr_q;
            end else begin
              state   <= S_PUSH;
              tx_data <= fifo_rdata;
              rd_cnt  <= LW'(1);
            end
          end
        end
        S_HDR: begin
          if (done_ok) begin
            state   <= S_PUSH;
            tx_data <= fifo_rdata;
            tx_vld  <= 1'b1;
            rd_cnt  <= LW'(1);
          end
        end
        S_PUSH: begin
          if (done_ok) begin
            if (rd_cnt == len_q) begin
              state      <= S_DONE;
              pending    <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              tx_data <= fifo_rdata;
              tx_vld  <= 1'b1;
              rd_cnt  <= rd_cnt + LW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (d_vld & ~buf_rdy & (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_chip_frame_push.sv
// tb/tb_chip_frame_push.sv - self-checking bench for chip_frame_push

module tb_chip_frame_push;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LW    = 20;
  localparam int DEPTH = 16;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_len;
  logic          cfg_single;
  logic          arm;
  logic          cfg_hdr_en;
  logic [DW-1:0] cfg_hdr;
  logic [DW-1:0] d_data;
  logic          d_vld;
  logic          buf_rdy;
  logic [DW-1:0] tx_data;
  logic          tx_vld;
  logic          tx_done;
  logic          busy;
  logic          frame_done;
  logic [15:0]   drop_cnt;

  chip_frame_push #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cfg_len    (cfg_len),
    .cfg_single (cfg_single),
    .arm        (arm),
    .cfg_hdr_en (cfg_hdr_en),
    .cfg_hdr    (cfg_hdr),
    .d_data     (d_data),
    .d_vld      (d_vld),
    .buf_rdy    (buf_rdy),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // UART model: records each word, answers tx_done resp_lat cycles later.
  logic [DW-1:0] obs_q[$];
  int exp_n     = 0;
  int resp_lat  = 5;
  bit resp_en   = 1'b1;
  bit spur_req  = 1'b0;
  int wait_cnt  = -1;
  bit done_prev = 1'b0;
  int exp_drop  = 0;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        tx_done   = 1'b0;
        wait_cnt  = -1;
        done_prev = 1'b0;
      end else begin
        if (done_prev) begin
          chk("done_to_vld", 32'(tx_vld), 32'(obs_q.size() < exp_n));
          chk("done_to_fd", 32'(frame_done), 32'(obs_q.size() >= exp_n));
        end
        done_prev = 1'b0;
        tx_done   = 1'b0;
        if (tx_vld) begin
          obs_q.push_back(tx_data);
          wait_cnt = resp_lat;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
        if (wait_cnt == 0 && resp_en) begin
          tx_done   = 1'b1;
          done_prev = 1'b1;
          wait_cnt  = -1;
        end else if (spur_req) begin
          tx_done  = 1'b1;
          spur_req = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input int len_cfg, input bit hen, input logic [DW-1:0] hdr,
                           input bit seq, input int gap_max, input bit stall,
                           input bit drop3, input bit single);
    int            len;
    int            n;
    bit            seen;
    logic [DW-1:0] s;
    logic [DW-1:0] exp_q[$];
    len = (len_cfg < 1) ? 1 : ((len_cfg > DEPTH) ? DEPTH : len_cfg);
    cfg_len    = LW'(len_cfg);
    cfg_hdr_en = hen;
    cfg_hdr    = hdr;
    obs_q.delete();
    if (hen) exp_q.push_back(hdr);
    exp_n = len + int'(hen);
    if (stall) resp_en = 1'b0;
    for (int i = 0; i < len; i++) begin
      n = $urandom_range(gap_max, 0);
      repeat (n) @(negedge clk_sys);
      s = seq ? DW'(i + 1) : DW'($urandom);
      exp_q.push_back(s);
      chk("buf_rdy_in", 32'(buf_rdy), 32'(1));
      d_data = s;
      d_vld  = 1'b1;
      @(negedge clk_sys);
      d_vld  = 1'b0;
      d_data = DW'($urandom);
      if (i == 0) begin
        // Configuration changes mid-frame must not affect this frame.
        cfg_hdr_en = ~hen;
        cfg_hdr    = ~hdr;
        cfg_len    = LW'($urandom_range(40, 0));
      end
    end
    chk("first_vld", 32'(tx_vld), 32'(1));
    chk("busy_run", 32'(busy), 32'(1));
    if (stall) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_sys);
        chk("stall_vld", 32'(tx_vld), 32'(0));
        chk("stall_data", 32'(tx_data), 32'(exp_q[0]));
      end
      resp_en = 1'b1;
    end
    if (drop3) begin
      for (int k = 0; k < 3; k++) begin
        d_vld  = 1'b1;
        d_data = DW'($urandom);
        @(negedge clk_sys);
      end
      d_vld = 1'b0;
      exp_drop += 3;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (frame_done) seen = 1'b1;
      else @(negedge clk_sys);
    end
    chk("frame_done_seen", 32'(seen), 32'(1));
    chk("buf_rdy_done", 32'(buf_rdy), 32'(0));
    @(negedge clk_sys);
    chk("fd_pulse", 32'(frame_done), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));
    chk("buf_rdy_after", 32'(buf_rdy), 32'(!single));
    chk("n_words", 32'(obs_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("word%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_len    = '0;
    cfg_single = 1'b0;
    arm        = 1'b0;
    cfg_hdr_en = 1'b0;
    cfg_hdr    = '0;
    d_data     = '0;
    d_vld      = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_tx_vld", 32'(tx_vld), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    chk("rst_buf_rdy", 32'(buf_rdy), 32'(1));
    cfg_single = 1'b1;
    #1 chk("rst_buf_rdy_single", 32'(buf_rdy), 32'(0));
    cfg_single = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);

    resp_lat = 5;
    run_frame(10, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(3, 1'b1, 16'hA55A, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Spurious tx_done while idle.
    spur_req = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("spur_busy", 32'(busy), 32'(0));
    chk("spur_vld", 32'(tx_vld), 32'(0));
    chk("spur_fd", 32'(frame_done), 32'(0));

    resp_lat = 1;
    run_frame(0, 1'b0, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 16'h1234, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    resp_lat = 0;
    run_frame(DEPTH + 5, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(DEPTH, 1'b1, 16'hBEEF, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    resp_lat = 5;
    run_frame(5, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    resp_lat = 2;
    run_frame(4, 1'b1, 16'hC3C3, 1'b0, 1, 1'b1, 1'b0, 1'b0);

    // Single-shot: samples before arm are dropped.
    cfg_single = 1'b1;
    @(negedge clk_sys);
    chk("ss_unarmed", 32'(buf_rdy), 32'(0));
    for (int k = 0; k < 4; k++) begin
      d_vld  = 1'b1;
      d_data = DW'($urandom);
      @(negedge clk_sys);
    end
    d_vld = 1'b0;
    exp_drop += 4;
    chk("ss_no_capture", 32'(busy), 32'(0));
    chk("ss_drop", 32'(drop_cnt), 32'(exp_drop));
    arm = 1'b1;
    @(negedge clk_sys);
    arm = 1'b0;
    chk("ss_armed", 32'(buf_rdy), 32'(1));
    resp_lat = 3;
    run_frame(5, 1'b0, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      d_vld  = 1'b1;
      d_data = DW'($urandom);
      @(negedge clk_sys);
    end
    d_vld = 1'b0;
    exp_drop += 2;
    chk("ss_no_second", 32'(busy), 32'(0));
    chk("ss_drop2", 32'(drop_cnt), 32'(exp_drop));
    arm = 1'b1;
    @(negedge clk_sys);
    arm = 1'b0;
    run_frame(2, 1'b1, 16'h5A5A, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cfg_single = 1'b0;
    @(negedge clk_sys);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      resp_lat = $urandom_range(4, 0);
      run_frame($urandom_range(DEPTH + 3, 0), 1'($urandom_range(1, 0)),
                DW'($urandom), 1'b0, 2, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of PUSH.
    resp_lat   = 5;
    cfg_len    = LW'(6);
    cfg_hdr_en = 1'b0;
    exp_n      = 6;
    obs_q.delete();
    for (int k = 0; k < 6; k++) begin
      d_vld  = 1'b1;
      d_data = DW'($urandom);
      @(negedge clk_sys);
    end
    d_vld = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_vld", 32'(tx_vld), 32'(0));
    chk("mid_rst_tx_data", 32'(tx_data), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_fd", 32'(frame_done), 32'(0));
    chk("mid_rst_buf_rdy", 32'(buf_rdy), 32'(1));
    chk("mid_rst_drop", 32'(drop_cnt), 32'(0));
    exp_drop = 0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    obs_q.delete();
    repeat (20) @(negedge clk_sys);
    chk("no_out_after_rst", 32'(obs_q.size()), 32'(0));
    chk("idle_after_rst", 32'(busy), 32'(0));
    resp_lat = 1;
    run_frame(7, 1'b1, 16'h7E7E, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_frame_push.md
# chip_frame_push

Parametrised frame buffer between the sample datapath and the UART transmitter. It captures a run-time-configurable number of samples into an internal FIFO. It then pushes them one word at a time to the UART with a valid/done handshake, optionally prefixed by a header word. It supports continuous or armed single-shot capture and reports dropped input samples.

## Interface
Parameters:
- DW, 16, sample/word width
- AW, 12, FIFO address width; depth = 2^AW words
- LW, 20, frame-length counter width

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_len  in  LW  samples per frame; sampled at frame start
- cfg_single  in  1  0 = continuous re-arm, 1 = single-shot (needs arm)
- arm  in  1  one-cycle pulse; arms one capture in single-shot mode
- cfg_hdr_en  in  1  emit cfg_hdr before the frame's samples
- cfg_hdr  in  DW  header word; sampled at frame start
- d_data  in  DW  sample data
- d_vld  in  1  sample strobe, one sample per cycle max
- buf_rdy  out  1  block accepts samples (IDLE-armed or BUF)
- tx_data  out  DW  word to UART; stable while its word is outstanding
- tx_vld  out  1  one-cycle pulse: tx_data is a new word
- tx_done  in  1  one-cycle pulse: UART finished current word
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last word's tx_done
- drop_cnt  out  16  saturating count of d_vld while buf_rdy = 0; cleared by reset only

## Operation
- Effective length: L = max(1, min(cfg_len, 2^AW)), latched as len_q on the IDLE->BUF transition.
- armed: set by reset if cfg_single = 0. Otherwise set by arm. Cleared on entering BUF when cfg_single = 1.
- FSM states: IDLE, BUF, HDR, PUSH, DONE.
  - IDLE: buf_rdy = armed. When d_vld & armed, write the sample (it counts as sample 1), latch len_q and hdr_q, and go to BUF. If L = 1, go directly to HDR/PUSH.
  - BUF: write every d_vld. When write count reaches len_q, go to HDR if cfg_hdr_en, else PUSH.
  - HDR: issue hdr_q, wait for tx_done, then go to PUSH.
  - PUSH: pop one FIFO word per issue. After tx_done of word len_q, go to DONE.
  - DONE: one cycle; frame_done = 1; go to IDLE. Re-arms automatically in continuous mode.
- Word issue: tx_vld pulses on the cycle after entering HDR/PUSH, and one cycle after each tx_done that is not the last. tx_data is registered with tx_vld and held until the next issue.
- tx_done outside HDR/PUSH, or with no outstanding word, is ignored.
- d_vld outside buf_rdy: the sample is discarded and drop_cnt increments, saturating at 16'hFFFF.
- The FIFO never overflows because L ≤ depth. It is empty at the end of every frame.
- Changes to cfg_* during a frame have no effect until the next frame start.

## Timing
- Reset values: tx_data 0, tx_vld 0, buf_rdy = ~cfg_single (armed state), busy 0, frame_done 0, drop_cnt 0. FSM goes to IDLE and the FIFO pointers are cleared.
- Reset asserted mid-frame discards the whole frame; no partial output follows reset release.
- The last sample write and the BUF exit happen in the same cycle. The first tx_vld follows 1 cycle later (HDR or PUSH entry + 1).
- tx_done -> next tx_vld latency: exactly 1 cycle.
- Last-word tx_done -> frame_done: 1 cycle (DONE). buf_rdy rises the cycle after DONE.
- Simultaneous arm and frame start: the arm is consumed by that frame.

## Structure
- Shared package chip_pkg: FSM state encoding (S_IDLE=0, S_BUF=1, S_HDR=2, S_PUSH=3, S_DONE=7) and the default frame length constant LEN_CHIP = 4000.
- One sub-module, sync_fifo #(DW, AW): single-clock, show-ahead, with empty/full/count outputs and async reset. Replaces the vendor FIFO instance.
- Top level holds the FSM, the len/write/read counters, the drop counter and the tx register.

## Test plan
- Continuous mode, cfg_len=10, hdr off, 10 samples 0x0001..0x000A, UART answering tx_done 5 cycles after each tx_vld -> exactly 10 tx_vld pulses with data 1..10 in order, then one frame_done, and buf_rdy back high.
- Header on, cfg_hdr=0xA55A, cfg_len=3 -> words A55A, s1, s2, s3; first tx_vld 1 cycle after the third sample.
- Single-shot: d_vld before arm -> drop_cnt counts and no capture occurs. After an arm pulse, one frame is captured; a second frame is not captured until another arm.
- Boundaries: cfg_len=0 -> 1-word frame. cfg_len=2^AW+5 -> 2^AW words. d_vld during PUSH for 3 cycles -> drop_cnt=3.
- A spurious tx_done in IDLE has no effect. A tx_done held low stalls output with tx_data stable.
- rst_n pulsed mid-PUSH -> all outputs return to reset values. The next frame delivers only new samples.
